// File: rtl/ifmap_spad_write_ctrl.sv
// Write-side sequencer for the circular IFMAP scratchpad: one row per start, wrapping pointer,
// occupancy tracking. Define IFMAP_STALL_CNT_EN to add the stall_cycles counter output.
module ifmap_spad_write_ctrl #(
  parameter int IF_DEPTH = 16,
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 16,
  parameter int LEN_W    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  row_len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic              rd_release,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W:0]   occupancy,
  output logic              full,
  output logic              busy,
`ifdef IFMAP_STALL_CNT_EN
  output logic [15:0]       stall_cycles,
`endif
  output logic              done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  ptr_q;
  logic [LEN_W-1:0]   word_cnt_q;
  logic [LEN_W-1:0]   row_len_q;
  logic               zero_done_q;
  logic               accept;
  logic               start_ok;
  logic               last_word;
  logic               release_ok;

  assign full       = (occupancy == (ADDR_W+1)'(IF_DEPTH));
  assign in_ready   = (state_q == S_WRITE) && !full;
  assign accept     = in_valid && in_ready;
  assign start_ok   = start && (state_q == S_IDLE);
  assign last_word  = accept && (word_cnt_q == row_len_q - LEN_W'(1));
  assign release_ok = rd_release && (occupancy != '0);
  assign busy       = (state_q != S_IDLE);
  // A zero-length row never leaves IDLE, so its done pulse comes from a separate flop.
  assign done       = (state_q == S_DONE) || zero_done_q;

  always_comb begin
    // NOTE: default assigned first so no path through the case can infer a latch.
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_ok && (row_len != '0)) state_d = S_WRITE;
      S_WRITE: if (last_word) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      zero_done_q <= 1'b0;
      row_len_q   <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      zero_done_q <= start_ok && (row_len == '0);
      if (start_ok) begin
        row_len_q  <= row_len;
        word_cnt_q <= '0;
      end else if (accept) begin
        word_cnt_q <= word_cnt_q + LEN_W'(1);
      end
    end
  end

  // Pointer survives across rows; only reset rewinds it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= ptr_q;
        wr_data <= in_data;
        ptr_q   <= (ptr_q == ADDR_W'(IF_DEPTH - 1)) ? '0 : ptr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupancy <= '0;
    end else begin
      case ({accept, release_ok})
        2'b10:   occupancy <= occupancy + (ADDR_W+1)'(1);
        2'b01:   occupancy <= occupancy - (ADDR_W+1)'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

`ifdef IFMAP_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (start_ok) begin
      stall_cycles <= '0;
    end else if ((state_q == S_WRITE) && in_valid && !in_ready && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifmap_spad_write_ctrl.sv
// Bench for ifmap_spad_write_ctrl: vector table, directed corner sequences and random traffic
// compared cycle by cycle against a row/occupancy model.
module tb_ifmap_spad_write_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  row_len = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        rd_release = 1'b0;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [4:0]  occupancy;
  logic        full;
  logic        busy;
  logic        done;
`ifdef IFMAP_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  ifmap_spad_write_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .row_len(row_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rd_release(rd_release), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .occupancy(occupancy), .full(full), .busy(busy),
`ifdef IFMAP_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model: words left in the current row, pending done pulses, pointer, occupancy.
  int m_left, m_ptr, m_occ, m_stall;
  bit m_row_done, m_zero_done, m_wr_en;
  int m_addr, m_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_left = 0; m_ptr = 0; m_occ = 0; m_stall = 0;
    m_row_done = 0; m_zero_done = 0; m_wr_en = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".in_ready"},  32'(in_ready),  32'((m_left > 0) && (m_occ < 16)));
    check({tag, ".wr_en"},     32'(wr_en),     32'(m_wr_en));
    check({tag, ".wr_addr"},   32'(wr_addr),   m_addr);
    check({tag, ".wr_data"},   32'(wr_data),   m_data);
    check({tag, ".occupancy"}, 32'(occupancy), m_occ);
    check({tag, ".full"},      32'(full),      32'(m_occ == 16));
    check({tag, ".busy"},      32'(busy),      32'((m_left > 0) || m_row_done));
    check({tag, ".done"},      32'(done),      32'(m_row_done || m_zero_done));
`ifdef IFMAP_STALL_CNT_EN
    check({tag, ".stall"},     32'(stall_cycles), m_stall);
`endif
  endtask

  // Apply one cycle of inputs, advance the clock, advance the model, compare.
  task automatic step(input string tag, input logic s, input logic [7:0] l, input logic v,
                      input logic [15:0] d, input logic r);
    bit idle, ready, acc, rel_ok, new_row_done, new_zero;
    start = s; row_len = l; in_valid = v; in_data = d; rd_release = r;
    @(posedge clk);
    #1;
    idle   = (m_left == 0) && !m_row_done;
    ready  = (m_left > 0) && (m_occ < 16);
    acc    = v && ready;
    rel_ok = r && (m_occ > 0);
    if ((m_left > 0) && v && !ready && (m_stall < 65535)) m_stall++;
    new_row_done = acc && (m_left == 1);
    new_zero     = s && idle && (l == 0);
    if (s && idle) begin
      m_stall = 0;
      if (l != 0) m_left = int'(l);
    end
    m_wr_en = acc;
    if (acc) begin
      m_addr = m_ptr;
      m_data = int'(d);
      m_ptr  = (m_ptr + 1) % 16;
      m_left--;
    end
    m_occ = m_occ + (acc ? 1 : 0) - (rel_ok ? 1 : 0);
    m_row_done  = new_row_done;
    m_zero_done = new_zero;
    compare_model(tag);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0; in_valid = 1'b0; rd_release = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic        s;
    logic [7:0]  l;
    logic        v;
    logic [15:0] d;
    logic        r;
    logic        e_en;
    logic [3:0]  e_addr;
    logic [15:0] e_data;
    logic [4:0]  e_occ;
    logic        e_ready;
    logic        e_busy;
    logic        e_done;
  } vec_t;

  vec_t t1 [7];

  initial begin
    int wr_count;
    logic [3:0] addrs [4];
    int n;

    // Row of 5 from reset: start cycle, five accepted words, DONE, back to IDLE.
    t1[0] = '{1'b1, 8'd5, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd0, 16'h0000, 5'd0, 1'b1, 1'b1, 1'b0};
    t1[1] = '{1'b0, 8'd0, 1'b1, 16'hA000, 1'b0, 1'b1, 4'd0, 16'hA000, 5'd1, 1'b1, 1'b1, 1'b0};
    t1[2] = '{1'b0, 8'd0, 1'b1, 16'hA001, 1'b0, 1'b1, 4'd1, 16'hA001, 5'd2, 1'b1, 1'b1, 1'b0};
    t1[3] = '{1'b0, 8'd0, 1'b1, 16'hA002, 1'b0, 1'b1, 4'd2, 16'hA002, 5'd3, 1'b1, 1'b1, 1'b0};
    t1[4] = '{1'b0, 8'd0, 1'b1, 16'hA003, 1'b0, 1'b1, 4'd3, 16'hA003, 5'd4, 1'b1, 1'b1, 1'b0};
    t1[5] = '{1'b0, 8'd0, 1'b1, 16'hA004, 1'b0, 1'b1, 4'd4, 16'hA004, 5'd5, 1'b0, 1'b1, 1'b1};
    t1[6] = '{1'b0, 8'd0, 1'b0, 16'h0000, 1'b0, 1'b0, 4'd4, 16'hA004, 5'd5, 1'b0, 1'b0, 1'b0};

    model_reset();
    #2;
    check("reset.busy", 32'(busy), 0);
    check("reset.wr_en", 32'(wr_en), 0);
    check("reset.occupancy", 32'(occupancy), 0);
    check("reset.done", 32'(done), 0);
    check("reset.in_ready", 32'(in_ready), 0);
    do_reset();

    for (int i = 0; i < 7; i++) begin
      step("t1", t1[i].s, t1[i].l, t1[i].v, t1[i].d, t1[i].r);
      check($sformatf("t1[%0d].wr_en", i),   32'(wr_en),     32'(t1[i].e_en));
      check($sformatf("t1[%0d].wr_addr", i), 32'(wr_addr),   32'(t1[i].e_addr));
      check($sformatf("t1[%0d].wr_data", i), 32'(wr_data),   32'(t1[i].e_data));
      check($sformatf("t1[%0d].occ", i),     32'(occupancy), 32'(t1[i].e_occ));
      check($sformatf("t1[%0d].ready", i),   32'(in_ready),  32'(t1[i].e_ready));
      check($sformatf("t1[%0d].busy", i),    32'(busy),      32'(t1[i].e_busy));
      check($sformatf("t1[%0d].done", i),    32'(done),      32'(t1[i].e_done));
    end

    // Zero-length row: done pulse without leaving IDLE; release honoured in IDLE.
    step("zero", 1'b1, 8'd0, 1'b0, 16'h0, 1'b1);
    check("zero.done", 32'(done), 1);
    check("zero.busy", 32'(busy), 0);
    check("zero.occ", 32'(occupancy), 4);

    // Fill to 16, back-pressure, then release while in_valid is held (no bypass).
    do_reset();
    wr_count = 0;
    step("fill", 1'b1, 8'd20, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      step("fill", 1'b0, 8'd0, 1'b1, 16'(16'hB000 + i), 1'b0);
      if (wr_en) wr_count++;
    end
    check("fill.words", wr_count, 16);
    check("fill.in_ready", 32'(in_ready), 0);
    check("fill.full", 32'(full), 1);
    check("fill.occ", 32'(occupancy), 16);
`ifdef IFMAP_STALL_CNT_EN
    // Two stalled cycles so far; five more full cycles make seven.
    for (int i = 0; i < 5; i++) step("stall", 1'b0, 8'd0, 1'b1, 16'hCCCC, 1'b0);
    check("stall.count7", 32'(stall_cycles), 7);
`endif
    for (int k = 0; k < 2; k++) begin
      step("relfull", 1'b0, 8'd0, 1'b1, 16'hBEEF, 1'b1);
      check("relfull.no_accept", 32'(wr_en), 0);
      check("relfull.occ15", 32'(occupancy), 15);
      step("relnext", 1'b0, 8'd0, 1'b1, 16'(16'hD000 + k), 1'b0);
      check("relnext.accept", 32'(wr_en), 1);
      if (wr_en) wr_count++;
    end
    check("fill.words18", wr_count, 18);
    n = 0;
    while (busy && n < 40) begin
      step("drain", 1'b0, 8'd0, 1'b1, 16'hE000, n[0]);
      n++;
    end
    check("drain.finished", 32'(busy), 0);
`ifdef IFMAP_STALL_CNT_EN
    step("stallclr", 1'b1, 8'd3, 1'b0, 16'h0, 1'b0);
    check("stall.cleared", 32'(stall_cycles), 0);
`endif

    // Pointer wrap: 14-word row, free everything in IDLE, then 4 words from address 14.
    do_reset();
    step("pre", 1'b1, 8'd14, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 15; i++) step("pre", 1'b0, 8'd0, 1'b1, 16'(i), 1'b0);
    for (int i = 0; i < 14; i++) step("free", 1'b0, 8'd0, 1'b0, 16'h0, 1'b1);
    check("wrap.occ0", 32'(occupancy), 0);
    step("wrap", 1'b1, 8'd4, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step("wrap", 1'b0, 8'd0, 1'b1, 16'(16'hF000 + i), 1'b0);
      addrs[i] = wr_addr;
    end
    check("wrap.a0", 32'(addrs[0]), 14);
    check("wrap.a1", 32'(addrs[1]), 15);
    check("wrap.a2", 32'(addrs[2]), 0);
    check("wrap.a3", 32'(addrs[3]), 1);
    check("wrap.occ4", 32'(occupancy), 4);

    // Asynchronous reset mid-row after three words.
    do_reset();
    step("abort", 1'b1, 8'd10, 1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 3; i++) step("abort", 1'b0, 8'd0, 1'b1, 16'(16'h9000 + i), 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("abort.busy", 32'(busy), 0);
    check("abort.occ", 32'(occupancy), 0);
    check("abort.wr_en", 32'(wr_en), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step("after", 1'b1, 8'd2, 1'b0, 16'h0, 1'b0);
    step("after", 1'b0, 8'd0, 1'b1, 16'h7777, 1'b0);
    check("after.addr0", 32'(wr_addr), 0);
    check("after.en", 32'(wr_en), 1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      step("rand", ($urandom_range(0, 7) == 0), 8'($urandom_range(0, 40)),
           ($urandom_range(0, 9) < 7), 16'($urandom), ($urandom_range(0, 9) < 4));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
